imm_pack: RTL and testbench

Immediate packer: the encode-side counterpart of the immediate extender. It accepts a 32-bit constant or a branch byte offset and emits one or two `{imm[15:0], EOp[1:0]}` beats. Feeding each beat through the extender, and ORing the results of a two-beat pair, reproduces the original value exactly. It sits in the assembler/loader path ahead of instruction-word formation and uses a valid/ready handshake on both sides.

---
 rtl/imm_pack_pkg.sv | 24 ++
 rtl/imm_classify.sv | 43 ++++
 rtl/imm_pack.sv | 75 +++++++
 tb/tb_imm_pack.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pack_pkg.sv
// rtl/imm_pack_pkg.sv - shared extender op codes, packer states and range helpers
package imm_pack_pkg;

    // Extender operations applied to a 16-bit immediate
    typedef enum logic [1:0] {
        EOP_SIGN  = 2'd0,   // sign-extend to 32 bits
        EOP_ZERO  = 2'd1,   // zero-extend to 32 bits
        EOP_UPPER = 2'd2,   // place in bits 31:16 (lui)
        EOP_SHL2  = 2'd3    // sign-extend then shift left by 2 (branch offset)
    } eop_t;

    // Packer output state
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,    // no beat presented
        ST_FINAL = 2'd1,    // presenting a last beat
        ST_HIGH  = 2'd2     // presenting the upper half of a pair; low half held in lo
    } state_t;

    // True when the value survives a 16-bit sign-extend round trip
    function automatic logic fits_s16(input logic [31:0] v);
        return v[31:16] == {16{v[15]}};
    endfunction

endpackage

// File: rtl/imm_classify.sv
// rtl/imm_classify.sv - combinational classifier choosing first-beat fields for a value
//
// Ports:
//   in_val   : value to encode
//   in_kind  : 0 = data constant, 1 = branch byte offset
//   imm_a    : immediate of the first (or only) beat
//   eop_a    : extender op of the first (or only) beat
//   two_beat : value needs an upper beat followed by a zero-extended low beat
//   err      : branch offset not representable (always 0 for data)
import imm_pack_pkg::*;

module imm_classify (
    input  logic [31:0] in_val,
    input  logic        in_kind,
    output logic [15:0] imm_a,
    output eop_t        eop_a,
    output logic        two_beat,
    output logic        err
);

    always_comb begin
        imm_a    = in_val[31:16];
        eop_a    = EOP_UPPER;
        two_beat = 1'b0;
        err      = 1'b0;
        if (in_kind) begin
            // Word-aligned offset reachable by an 18-bit signed byte displacement
            imm_a = in_val[17:2];
            eop_a = EOP_SHL2;
            err   = !((in_val[1:0] == 2'b00) && (in_val[31:17] == {15{in_val[17]}}));
        end else if (fits_s16(in_val)) begin
            imm_a = in_val[15:0];
            eop_a = EOP_SIGN;
        end else if (in_val[31:16] == 16'h0000) begin
            imm_a = in_val[15:0];
            eop_a = EOP_ZERO;
        end else if (in_val[15:0] != 16'h0000) begin
            // Upper half goes first; the low half follows as a zero-extended beat
            two_beat = 1'b1;
        end
    end

endmodule

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - immediate packer emitting one or two {imm, eop} beats per value
//
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake
//   in_val, in_kind      : value to encode and its kind (0 data, 1 branch offset)
//   out_valid/out_ready  : output handshake
//   out_imm, out_eop     : immediate field and extender op of the presented beat
//   out_last             : final beat of the current input
//   out_err              : branch offset not representable; consumer drops the beat
import imm_pack_pkg::*;

module imm_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_val,
    input  logic        in_kind,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [1:0]  out_eop,
    output logic        out_last,
    output logic        out_err
);

    state_t      state;
    logic [15:0] lo;

    logic [15:0] c_imm;
    eop_t        c_eop;
    logic        c_two;
    logic        c_err;

    imm_classify u_classify (
        .in_val   (in_val),
        .in_kind  (in_kind),
        .imm_a    (c_imm),
        .eop_a    (c_eop),
        .two_beat (c_two),
        .err      (c_err)
    );

    // A new input may replace the final beat in the same cycle it is consumed
    assign in_ready  = (state == ST_EMPTY) || ((state == ST_FINAL) && out_ready);
    assign out_valid = (state != ST_EMPTY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            lo       <= 16'h0000;
            out_imm  <= 16'h0000;
            out_eop  <= 2'd0;
            out_last <= 1'b0;
            out_err  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_imm  <= c_imm;
            out_eop  <= c_eop;
            out_last <= !c_two;
            out_err  <= c_err;
            lo       <= in_val[15:0];
            state    <= c_two ? ST_HIGH : ST_FINAL;
        end else if ((state == ST_HIGH) && out_ready) begin
            out_imm  <= lo;
            out_eop  <= EOP_ZERO;
            out_last <= 1'b1;
            out_err  <= 1'b0;
            state    <= ST_FINAL;
        end else if ((state == ST_FINAL) && out_ready) begin
            state    <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - self-checking bench for imm_pack
module tb_imm_pack;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_val = 32'h0;
    logic        in_kind = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    // Beats are packed as {imm[15:0], eop[1:0], last, err}
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    logic [32:0] in_q[$];

    always #5 clk = ~clk;

    imm_pack dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .in_kind   (in_kind),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_eop   (out_eop),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    // Reference: encoding chosen by numeric range of the value
    task automatic model_push(input logic [31:0] v, input logic k);
        int sv;
        logic ok;
        sv = $signed(v);
        if (!k) begin
            if (sv >= -32768 && sv <= 32767)      exp_q.push_back({v[15:0], 2'd0, 1'b1, 1'b0});
            else if (v < 32'h0001_0000)           exp_q.push_back({v[15:0], 2'd1, 1'b1, 1'b0});
            else if ((v % 32'h0001_0000) == 0)    exp_q.push_back({v[31:16], 2'd2, 1'b1, 1'b0});
            else begin
                exp_q.push_back({v[31:16], 2'd2, 1'b0, 1'b0});
                exp_q.push_back({v[15:0], 2'd1, 1'b1, 1'b0});
            end
        end else begin
            ok = ((v % 4) == 0) && (sv >= -131072) && (sv <= 131071);
            exp_q.push_back({v[17:2], 2'd3, 1'b1, !ok});
        end
    endtask

    // Reference extender
    function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] eop);
        int s;
        s = $signed(imm);
        case (eop)
            2'd0:    return s;
            2'd1:    return 32'(imm);
            2'd2:    return 32'(imm) * 32'h0001_0000;
            default: return s * 4;
        endcase
    endfunction

    function automatic logic [32:0] rand_input();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 6);
        case (sel)
            0:       return {1'b0, {16{r[15]}}, r[15:0]};
            1:       return {1'b0, 16'h0000, r[15:0]};
            2:       return {1'b0, r[31:16], 16'h0000};
            3:       return {1'b0, r};
            4:       return {1'b1, {14{r[17]}}, r[17:2], 2'b00};
            5:       return {1'b1, r};
            default: return {1'b1, {14{r[17]}}, r[17:0]};
        endcase
    endfunction

    // Sends one input with out_ready high and collects its beats
    task automatic drive_and_collect(input logic [31:0] v, input logic k,
                                     output logic [19:0] b0, output logic [19:0] b1,
                                     output int n, output logic to, output logic hi_rdy);
        int c;
        logic acc, done;
        b0 = 20'h0; b1 = 20'h0; n = 0; to = 1'b0; hi_rdy = 1'b1;
        in_val = v; in_kind = k; in_valid = 1'b1; out_ready = 1'b1;
        acc = 1'b0; c = 0;
        while (!acc && c < 20) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        in_valid = 1'b0;
        if (!acc) to = 1'b1;
        done = 1'b0; c = 0;
        while (!done && c < 20) begin
            @(negedge clk);
            if (out_valid) begin
                if (n == 0) b0 = {out_imm, out_eop, out_last, out_err};
                else        b1 = {out_imm, out_eop, out_last, out_err};
                if (!out_last) hi_rdy = in_ready;
                n++;
                if (out_last) done = 1'b1;
            end
            @(posedge clk); #1;
            c++;
        end
        if (!done) to = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_imm, out_eop, out_last, out_err} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_imm, out_eop, out_last, out_err});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_data_classes();
        logic [31:0] vals [4] = '{32'hFFFF8000, 32'h0000FFFF, 32'h12340000, 32'h12345678};
        logic [19:0] e0 [4] = '{{16'h8000, 2'd0, 2'b10}, {16'hFFFF, 2'd1, 2'b10},
                                {16'h1234, 2'd2, 2'b10}, {16'h1234, 2'd2, 2'b00}};
        logic [19:0] b0, b1;
        int n;
        logic to, hr;
        for (int i = 0; i < 4; i++) begin
            drive_and_collect(vals[i], 1'b0, b0, b1, n, to, hr);
            checks++;
            if (to !== 1'b0 || n !== ((i == 3) ? 2 : 1)) begin
                failures++;
                $display("FAIL data_count val=%h got_n=%0d timeout=%b exp_n=%0d", vals[i], n, to, (i == 3) ? 2 : 1);
            end
            checks++;
            if (b0 !== e0[i]) begin
                failures++;
                $display("FAIL data_beat0 val=%h got=%h exp=%h", vals[i], b0, e0[i]);
            end
        end
        checks++;
        if (b1 !== {16'h5678, 2'd1, 2'b10}) begin
            failures++;
            $display("FAIL data_beatB got=%h exp=%h", b1, {16'h5678, 2'd1, 2'b10});
        end
        checks++;
        if (hr !== 1'b0) begin
            failures++;
            $display("FAIL in_ready_during_A got=%b exp=0", hr);
        end
    endtask

    task automatic test_branch();
        logic [31:0] vals [3] = '{32'hFFFFFFFC, 32'h00020000, 32'h00000006};
        logic [19:0] ex [3] = '{{16'hFFFF, 2'd3, 2'b10}, {16'h8000, 2'd3, 2'b11},
                                {16'h0001, 2'd3, 2'b11}};
        logic [19:0] b0, b1;
        int n;
        logic to, hr;
        for (int i = 0; i < 3; i++) begin
            drive_and_collect(vals[i], 1'b1, b0, b1, n, to, hr);
            checks++;
            if (to !== 1'b0 || n !== 1 || b0 !== ex[i]) begin
                failures++;
                $display("FAIL branch val=%h got=%h n=%0d timeout=%b exp=%h", vals[i], b0, n, to, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [8];
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r = 16'($urandom);
            vals[i] = {{16{r[15]}}, r};
        end
        out_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                in_val = vals[c]; in_kind = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready cycle=%0d got=%b exp=1", c, in_ready);
                end
            end
            if (c > 0) begin
                checks++;
                if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, vals[c-1][15:0], 2'd0, 1'b1}) begin
                    failures++;
                    $display("FAIL b2b_out cycle=%0d got=%h exp=%h", c,
                             {out_valid, out_imm, out_eop, out_last}, {1'b1, vals[c-1][15:0], 2'd0, 1'b1});
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_stream();
        logic prev_stall;
        logic [19:0] prev_f, cur_f, b;
        logic [32:0] inp;
        logic [31:0] acc;
        logic exp_rdy, any_err;
        int j;
        exp_q.delete(); obs_q.delete(); in_q.delete();
        prev_stall = 1'b0; prev_f = 20'h0;
        for (int c = 0; c < 400; c++) begin
            inp = rand_input();
            in_kind = inp[32]; in_val = inp[31:0];
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cur_f = {out_imm, out_eop, out_last, out_err};
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || cur_f !== prev_f) begin
                    failures++;
                    $display("FAIL stall_stable cycle=%0d got=%b/%h exp=1/%h", c, out_valid, cur_f, prev_f);
                end
            end
            exp_rdy = !out_valid ? 1'b1 : (out_last ? out_ready : 1'b0);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rand_in_ready cycle=%0d got=%b exp=%b", c, in_ready, exp_rdy);
            end
            if (out_valid && out_ready) obs_q.push_back(cur_f);
            if (in_valid && in_ready) begin
                in_q.push_back({in_kind, in_val});
                model_push(in_val, in_kind);
            end
            prev_stall = out_valid && !out_ready;
            prev_f = cur_f;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) obs_q.push_back({out_imm, out_eop, out_last, out_err});
            @(posedge clk); #1;
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL rand_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_beat idx=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        // Extender round trip: OR of the beats of each input reproduces it
        j = 0;
        foreach (in_q[k]) begin
            acc = 32'h0; any_err = 1'b0;
            while (j < obs_q.size()) begin
                b = obs_q[j];
                j++;
                acc = acc | ext(b[19:4], b[3:2]);
                any_err = any_err | b[0];
                if (b[1]) break;
            end
            checks++;
            if (any_err ? (in_q[k][32] !== 1'b1) : (acc !== in_q[k][31:0])) begin
                failures++;
                $display("FAIL roundtrip idx=%0d got=%h err=%b exp=%h kind=%b", k, acc, any_err, in_q[k][31:0], in_q[k][32]);
            end
        end
    endtask

    task automatic test_reset_mid_pair();
        int seen;
        in_val = 32'h12345678; in_kind = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midpair_accept got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, 16'h1234, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL midpair_beatA got=%h exp=%h", {out_valid, out_imm, out_eop, out_last}, {1'b1, 16'h1234, 2'd2, 1'b0});
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midpair_after_reset got_valid=%b got_ready=%b exp=0/1", out_valid, in_ready);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midpair_no_beatB got=%0d exp=0", seen);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_data_classes();
        test_branch();
        test_back_to_back();
        test_random_stream();
        test_reset_mid_pair();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
